instr_encoder_loader: RTL

- Encoder counterpart to the main control decoder.
- Accepts instruction requests as kind plus fields through a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it into instruction memory at sequential word-aligned addresses.
- Used by testbenches and boot logic to load programs built from R-type, addi, beq and slti instructions.

---
 rtl/instr_encoder_loader_pkg.sv | 32 +++
 rtl/instr_field_packer.sv | 32 +++
 rtl/instr_encoder_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder_loader_pkg                                              |
// | Opcodes, request kinds and loader states shared by encoder/decoder.   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [1:0] {
        KIND_R    = 2'b00,
        KIND_ADDI = 2'b01,
        KIND_BEQ  = 2'b10,
        KIND_SLTI = 2'b11
    } kind_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_FULL  = 3'd2,
`ifdef INSTR_LOADER_NOP_PAD_EN
        ST_PAD   = 3'd4,
`endif
        ST_DONE  = 3'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_field_packer                                                    |
// | Combinational packing of request kind + fields into a MIPS word.      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = 32'h0000_0000;
        case (kind_t'(kind))
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_SLTI: word = {OP_SLTI, rs, rt, imm};
            default:   word = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder_loader                                                  |
// | Encodes instruction requests and writes them to sequential words.     |
// | Option: INSTR_LOADER_NOP_PAD_EN pads remaining memory with nops.      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = 5
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic              done_i,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              load_done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(MEM_DEPTH - 1);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [ADDR_W:0]  r_count;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic             r_err;
    logic [31:0]      w_word;
    logic             w_accept;
    logic             w_last_cnt;

    // Byte address of a word index; count's top bit is never an index bit.
    function automatic logic [31:0] word_addr(input logic [ADDR_W:0] cnt);
        word_addr = 32'(cnt[ADDR_W-1:0]) << 2;
    endfunction

    instr_field_packer u_packer (
        .kind  (kind_i),
        .rs    (rs_i),
        .rt    (rt_i),
        .rd    (rd_i),
        .shamt (shamt_i),
        .funct (funct_i),
        .imm   (imm_i),
        .word  (w_word)
    );

    assign w_accept   = (r_state == ST_IDLE) && req_valid_i;
    assign w_last_cnt = (r_count == c_last);

`ifdef INSTR_LOADER_NOP_PAD_EN
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(MEM_DEPTH);
    logic w_full_cnt;
    assign w_full_cnt = (r_count == c_depth);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_WRITE;
                end else if (done_i) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
                    w_next = ST_PAD;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_WRITE: begin
                w_next = w_last_cnt ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
                if (done_i) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
                    w_next = ST_PAD;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef INSTR_LOADER_NOP_PAD_EN
            ST_PAD: begin
                if (w_full_cnt || w_last_cnt) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address/data registers only move when a write is about to be shown,
    // so they hold their last written values otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_addr  <= 32'h0000_0000;
            r_data  <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= w_word;
                r_addr <= word_addr(r_count);
            end
            if (r_state == ST_WRITE) begin
                r_count <= r_count + 1'b1;
            end
            if (((r_state == ST_FULL) || (r_state == ST_DONE)) && req_valid_i) begin
                r_err <= 1'b1;
            end
`ifdef INSTR_LOADER_NOP_PAD_EN
            if ((r_state == ST_IDLE) && (w_next == ST_PAD)) begin
                r_addr <= word_addr(r_count);
                r_data <= 32'h0000_0000;
            end
            if ((r_state == ST_PAD) && !w_full_cnt) begin
                r_count <= r_count + 1'b1;
                if (!w_last_cnt) begin
                    r_addr <= word_addr(r_count + 1'b1);
                end
            end
`endif
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
`ifdef INSTR_LOADER_NOP_PAD_EN
    assign mem_we_o    = (r_state == ST_WRITE) || ((r_state == ST_PAD) && !w_full_cnt);
`else
    assign mem_we_o    = (r_state == ST_WRITE);
`endif
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign count_o     = r_count;
    assign full_o      = (r_state == ST_FULL);
    assign load_done_o = (r_state == ST_DONE);
    assign err_o       = r_err;

endmodule
`default_nettype wire
